// File: rtl/uart_reg_bridge_pkg.sv
// Shared types and constants for the UART register bridge.
// Holds the command byte layout, the bridge state encoding and error bit indices.
// No logic; imported by the bridge and its timer.
package uart_reg_bridge_pkg;

    // Command byte: bit 7 selects write, bits 6:0 address the register.
    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
    } uart_cmd_t;

    typedef enum logic [1:0] {
        BR_IDLE    = 2'd0,
        BR_WR_DATA = 2'd1,
        BR_RD_RESP = 2'd2
    } bridge_state_t;

    // Bit positions inside the sticky err vector {ovr, tmo, addr}.
    localparam int ERR_ADDR = 0;
    localparam int ERR_TMO  = 1;
    localparam int ERR_OVR  = 2;
    localparam int ERR_W    = 3;

    // Number of bytes needed to carry a register of the given width.
    function automatic int bytes_for(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// Byte-stream link between the UART receiver/transmitter and the bridge.
// Combinational bundle, no latency.
// tx side is valid/ready: tx_data holds while tx_valid is high and tx_ready is low.
interface uart_reg_bridge_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Drives bytes in and accepts response bytes (UART side / testbench).
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    // Consumes command bytes and produces response bytes (bridge side).
    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/uart_reg_bridge_frame_timer.sv
// Inter-byte watchdog: counts cycles since the last restart while enabled.
// expired is combinational from the count; it rises TIMEOUT_CYC enabled cycles after a restart.
// No backpressure; restart has priority over expiry.
module uart_frame_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CW-1:0] cnt;

    // Reload on every byte, otherwise count down to zero while the frame is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= CW'(TIMEOUT_CYC - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // A byte arriving in the same cycle as expiry wins, so expiry is masked by restart.
    assign expired = en && !restart && (cnt == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// Decodes UART command bytes into register writes and snapshot read-backs over TX.
// Write commits at the last data byte edge (wr_stb the next cycle); first TX byte 1 cycle after the read cmd.
// TX response waits on tx_ready with tx_data held; bytes arriving during a response are dropped (ovr).
module uart_reg_bridge
    import uart_reg_bridge_pkg::*;
#(
    parameter int REG_W       = 16,
    parameter int NUM_RW      = 4,
    parameter int NUM_RO      = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_reg_bridge_if.slave         uart,
    input  logic [NUM_RO*REG_W-1:0]  sts_in,
    output logic [NUM_RW*REG_W-1:0]  reg_q,
    output logic [NUM_RW-1:0]        wr_stb,
    input  logic                     err_clr,
    output logic [ERR_W-1:0]         err
);
    localparam int BYTES = bytes_for(REG_W);
    localparam int SH_W  = BYTES * 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [7:0]       RW_LIM    = 8'(NUM_RW);
    localparam logic [7:0]       ALL_LIM   = 8'(NUM_RW + NUM_RO);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    uart_cmd_t      cmd;
    bridge_state_t  state;
    logic [6:0]     addr;
    logic [CNT_W-1:0] byte_cnt;
    logic [SH_W-1:0]  wr_buf;
    logic [SH_W-1:0]  wr_asm;
    logic [SH_W-1:0]  rd_val;
    logic [SH_W-1:0]  resp_shift;
    logic             resp_valid;
    logic [REG_W-1:0] regs [NUM_RW];
    logic             last_byte;
    logic             wr_addr_ok;
    logic             rd_addr_ok;
    logic             timer_en;
    logic             expired;
    logic             tmo_hit;
    logic [ERR_W-1:0] err_set;

    assign cmd        = uart_cmd_t'(uart.rx_data);
    assign last_byte  = (byte_cnt == LAST_BYTE);
    assign wr_addr_ok = ({1'b0, addr} < RW_LIM);
    assign rd_addr_ok = ({1'b0, cmd.addr} < ALL_LIM);
    assign timer_en   = (state == BR_WR_DATA);
    assign tmo_hit    = (state == BR_WR_DATA) && !uart.rx_valid && expired;

    // tx_data is the low byte of the response shifter, so it is stable between accepts.
    assign uart.tx_data  = resp_shift[7:0];
    assign uart.tx_valid = resp_valid;

    for (genvar i = 0; i < NUM_RW; i++) begin : g_pack
        assign reg_q[i*REG_W +: REG_W] = regs[i];
    end

    uart_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (uart.rx_valid),
        .en      (timer_en),
        .expired (expired)
    );

    // Merge the incoming data byte into the partially assembled word at byte_cnt.
    always_comb begin
        wr_asm = wr_buf;
        for (int b = 0; b < BYTES; b++) begin
            if (byte_cnt == CNT_W'(b)) begin
                wr_asm[b*8 +: 8] = uart.rx_data;
            end
        end
    end

    // Look up the register named by the incoming cmd byte; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (cmd.addr == 7'(i)) begin
                rd_val[REG_W-1:0] = regs[i];
            end
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (cmd.addr == 7'(NUM_RW + k)) begin
                rd_val[REG_W-1:0] = sts_in[k*REG_W +: REG_W];
            end
        end
    end

    // Error events raised this cycle, one per sticky flag.
    always_comb begin
        err_set = '0;
        err_set[ERR_ADDR] = ((state == BR_IDLE) && uart.rx_valid && !cmd.wr && !rd_addr_ok)
                         || ((state == BR_WR_DATA) && uart.rx_valid && last_byte && !wr_addr_ok);
        err_set[ERR_TMO]  = tmo_hit;
        err_set[ERR_OVR]  = (state == BR_RD_RESP) && uart.rx_valid;
    end

    // Sticky error flags: a new event in the clear cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= '0;
        end else begin
            err <= (err_clr ? '0 : err) | err_set;
        end
    end

    // Frame FSM with byte assembly, register commit and read response shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BR_IDLE;
            addr       <= '0;
            byte_cnt   <= '0;
            wr_buf     <= '0;
            resp_shift <= '0;
            resp_valid <= 1'b0;
            wr_stb     <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_stb <= '0;
            case (state)
                BR_IDLE: begin
                    if (uart.rx_valid) begin
                        addr     <= cmd.addr;
                        byte_cnt <= '0;
                        if (cmd.wr) begin
                            wr_buf <= '0;
                            state  <= BR_WR_DATA;
                        end else begin
                            // Snapshot now so later register changes cannot tear the response.
                            resp_shift <= rd_val;
                            resp_valid <= 1'b1;
                            state      <= BR_RD_RESP;
                        end
                    end
                end
                BR_WR_DATA: begin
                    if (uart.rx_valid) begin
                        wr_buf <= wr_asm;
                        if (last_byte) begin
                            byte_cnt <= '0;
                            state    <= BR_IDLE;
                            // Unmapped addresses match no index, so nothing commits.
                            for (int i = 0; i < NUM_RW; i++) begin
                                if (addr == 7'(i)) begin
                                    regs[i]   <= wr_asm[REG_W-1:0];
                                    wr_stb[i] <= 1'b1;
                                end
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end else if (tmo_hit) begin
                        byte_cnt <= '0;
                        wr_buf   <= '0;
                        state    <= BR_IDLE;
                    end
                end
                BR_RD_RESP: begin
                    if (resp_valid && uart.tx_ready) begin
                        resp_shift <= resp_shift >> 8;
                        if (last_byte) begin
                            byte_cnt   <= '0;
                            resp_valid <= 1'b0;
                            state      <= BR_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= BR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed plus randomized bench for uart_reg_bridge (REG_W=16, NUM_RW=4, NUM_RO=2, TIMEOUT_CYC=50).
// Reference model: plain register array, status array, sticky error bits and per-read expected byte list.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_reg_bridge;
    localparam int REG_W  = 16;
    localparam int NUM_RW = 4;
    localparam int NUM_RO = 2;
    localparam int TMO    = 50;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_RO*REG_W-1:0] sts_in;
    logic [NUM_RW*REG_W-1:0] reg_q;
    logic [NUM_RW-1:0]       wr_stb;
    logic                    err_clr;
    logic [2:0]              err;

    uart_reg_bridge_if bus ();

    uart_reg_bridge #(
        .REG_W       (REG_W),
        .NUM_RW      (NUM_RW),
        .NUM_RO      (NUM_RO),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart    (bus),
        .sts_in  (sts_in),
        .reg_q   (reg_q),
        .wr_stb  (wr_stb),
        .err_clr (err_clr),
        .err     (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [NUM_RW];
    logic [15:0] m_sts  [NUM_RO];
    logic [2:0]  m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_pack();
        logic [63:0] v;
        for (int i = 0; i < NUM_RW; i++) v[i*16 +: 16] = m_regs[i];
        return v;
    endfunction

    function automatic logic [15:0] m_read(input int a);
        if (a < NUM_RW) return m_regs[a];
        if (a < NUM_RW + NUM_RO) return m_sts[a - NUM_RW];
        return 16'h0000;
    endfunction

    task automatic drive_sts();
        for (int k = 0; k < NUM_RO; k++) sts_in[k*16 +: 16] = m_sts[k];
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 3'b000;
        chk("err_after_clr", err, 3'b000);
    endtask

    // Full write frame; model commits only to mapped addresses.
    task automatic do_write(input int a, input logic [15:0] d);
        logic [3:0] exp_stb;
        send_byte({1'b1, 7'(a)});
        send_byte(d[7:0]);
        send_byte(d[15:8]);
        exp_stb = 4'b0000;
        if (a < NUM_RW) begin
            m_regs[a] = d;
            exp_stb[a] = 1'b1;
        end else begin
            m_err[0] = 1'b1;
        end
        chk("wr_stb_pulse", wr_stb, exp_stb);
        chk("wr_reg_q", reg_q, m_pack());
        @(negedge clk);
        chk("wr_stb_clear", wr_stb, 4'b0000);
    endtask

    // Read frame with optional stalls, a status change mid-response and an injected rx byte.
    task automatic do_read(input int a, input int stall, input bit mutate, input bit inject);
        logic [15:0] v;
        logic [7:0]  eb;
        v = m_read(a);
        if (a >= NUM_RW + NUM_RO) m_err[0] = 1'b1;
        send_byte({1'b0, 7'(a)});
        chk("rd_first_valid", bus.tx_valid, 1'b1);
        for (int b = 0; b < 2; b++) begin
            eb = v[b*8 +: 8];
            for (int s = 0; s < stall; s++) begin
                bus.tx_ready = 1'b0;
                if (mutate && b == 0 && s == 0) begin
                    for (int k = 0; k < NUM_RO; k++) m_sts[k] = 16'($urandom);
                    drive_sts();
                end
                chk("rd_hold_valid", bus.tx_valid, 1'b1);
                chk("rd_hold_data", bus.tx_data, eb);
                @(negedge clk);
            end
            chk("rd_valid", bus.tx_valid, 1'b1);
            chk("rd_data", bus.tx_data, eb);
            bus.tx_ready = 1'b1;
            if (inject && b == 0) begin
                bus.rx_data  = 8'($urandom);
                bus.rx_valid = 1'b1;
                m_err[2] = 1'b1;
            end
            @(negedge clk);
            bus.tx_ready = 1'b0;
            bus.rx_valid = 1'b0;
        end
        chk("rd_done_valid", bus.tx_valid, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        err_clr      = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < NUM_RW; i++) m_regs[i] = 16'h0000;
        m_sts[0] = 16'hBEEF;
        m_sts[1] = 16'h5A5A;
        drive_sts();
        m_err = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_reg_q", reg_q, 64'h0);
        chk("rst_wr_stb", wr_stb, 4'b0000);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_err", err, 3'b000);

        // Write 0x1234 to reg 1, then read it back
        do_write(1, 16'h1234);
        chk("wr1_reg1", reg_q[31:16], 16'h1234);
        chk("wr1_err", err, 3'b000);
        do_read(1, 0, 1'b0, 1'b0);

        // RO read with backpressure and a status change during the response
        m_sts[0] = 16'hBEEF;
        drive_sts();
        do_read(4, 5, 1'b1, 1'b0);
        chk("ro_err", err, 3'b000);

        // Timeout drops the partial frame
        send_byte(8'h82);
        send_byte(8'h55);
        repeat (60) @(negedge clk);
        m_err[1] = 1'b1;
        chk("tmo_err", err, 3'b010);
        chk("tmo_reg_q", reg_q, m_pack());
        clear_err();
        do_write(2, 16'h0001);
        chk("tmo_next_reg2", reg_q[47:32], 16'h0001);

        // A long gap well inside the timeout still completes the frame
        send_byte(8'h83);
        send_byte(8'hAB);
        repeat (40) @(negedge clk);
        send_byte(8'hCD);
        m_regs[3] = 16'hCDAB;
        chk("gap_reg_q", reg_q, m_pack());
        chk("gap_err", err, 3'b000);

        // Bad write address with err_clr in the same cycle as the error: set wins
        send_byte(8'h85);
        send_byte(8'hAA);
        err_clr = 1'b1;
        send_byte(8'hBB);
        err_clr = 1'b0;
        chk("badwr_stb", wr_stb, 4'b0000);
        chk("badwr_reg_q", reg_q, m_pack());
        chk("badwr_err", err, 3'b001);
        clear_err();

        // Overrun during a response; response still completes
        do_read(0, 2, 1'b0, 1'b1);
        chk("ovr_err", err, 3'b100);
        clear_err();

        // Unmapped read returns zeros and flags addr
        do_read(127, 1, 1'b0, 1'b0);
        chk("badrd_err", err, m_err);
        clear_err();

        // Randomized mixed traffic against the model
        for (int it = 0; it < 24; it++) begin
            int op;
            int a;
            op = $urandom_range(0, 1);
            a  = $urandom_range(0, 7);
            if (op == 0) do_write(a, 16'($urandom));
            else do_read(a, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
            chk("rand_err", err, m_err);
            chk("rand_reg_q", reg_q, m_pack());
            clear_err();
        end

        // Reset in the middle of a write frame
        send_byte(8'h83);
        send_byte(8'h11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_RW; i++) m_regs[i] = 16'h0000;
        m_err = 3'b000;
        chk("mrst_reg_q", reg_q, 64'h0);
        chk("mrst_wr_stb", wr_stb, 4'b0000);
        chk("mrst_tx_valid", bus.tx_valid, 1'b0);
        chk("mrst_tx_data", bus.tx_data, 8'h00);
        chk("mrst_err", err, 3'b000);
        clear_err();
        do_write(3, 16'h6677);
        chk("mrst_err_final", err, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
